uart_periph: RTL and testbench
==============================

UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 SHALL have parameter SYS_FREQ, default 25000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115200, reset baud rate; reset divisor = SYS_FREQ/BAUDRATE (integer).
REQ-003 SHALL have parameter RX_DEPTH_LOG2, default 3, RX FIFO depth = 2**RX_DEPTH_LOG2 bytes.
REQ-004 SHALL have parameter TX_DEPTH_LOG2, default 3, TX FIFO depth = 2**TX_DEPTH_LOG2 bytes.
REQ-005 SHALL have ports:
 i_clk  in  1  clock, rising edge
 i_reset  in  1  asynchronous, active-high reset
 i_slave_cs  in  1  bus select
 i_slave_we  in  1  write strobe, valid with cs
 i_slave_addr  in  3  register address
 i_slave_data  in  8  write data
 o_slave_data  out  8  read data, combinational from addr
 o_slave_ack  out  1  registered ack
 o_int  out  1  level interrupt
 i_uart_rx  in  1  serial input, asynchronous
 o_uart_tx  out  1  serial output, idle high

Function
REQ-006 Register map SHALL be: 0 STATUS, 1 DATA, 2 DIV_LO, 3 DIV_HI, 4 IRQ_EN, 5 CTRL; 6-7 read 0, writes ignored.
REQ-007 STATUS SHALL read {1'b0, framing_err, overrun, tx_busy, tx_full, tx_empty, rx_full, rx_empty} (bit7..0).
REQ-008 STATUS write SHALL: bit0=1 pop RX FIFO (no-op if empty); bit5=1 clear overrun; bit6=1 clear framing_err.
REQ-009 DATA read SHALL return RX FIFO head without popping; DATA write SHALL push TX FIFO; write when full SHALL be dropped.
REQ-010 DIV_LO/DIV_HI SHALL form a 16-bit divisor (clocks per bit), read-back exact; values below 4 SHALL be used as 4.
REQ-011 Divisor change SHALL take effect at next bit boundary of each engine, never mid-bit.
REQ-012 IRQ_EN bits[3:0] SHALL enable {framing_err, overrun, rx_not_empty, tx_empty}; o_int = OR of enabled sources, combinational from registered state.
REQ-013 o_slave_ack SHALL equal i_slave_cs delayed one cycle; every access cycle with cs high SHALL act once per cycle cs and we are high.
REQ-014 Frame format SHALL be 8N1, LSB first.
REQ-015 i_uart_rx SHALL pass a 2-flop synchroniser before use.
REQ-016 RX FSM states IDLE, START, DATA, STOP: IDLE->START on synchronised falling edge; START samples at divisor/2, returns IDLE if line high (glitch); DATA samples 8 bits each divisor clocks; STOP samples stop bit.
REQ-017 Stop bit low SHALL discard byte, set framing_err, go IDLE after line high.
REQ-018 Valid byte with RX FIFO full SHALL be dropped and set overrun; FIFO contents unchanged.
REQ-019 TX FSM states IDLE, START, DATA, STOP: IDLE pops TX FIFO when not empty and enters START same cycle; each bit lasts divisor clocks; STOP->IDLE; back-to-back bytes SHALL have no idle gap.
REQ-020 tx_busy SHALL be 1 in any TX state other than IDLE.
REQ-021 Simultaneous RX push and pop SHALL both take effect, count unchanged; simultaneous pop-on-empty SHALL not corrupt pointers.
REQ-022 Simultaneous set and clear of a sticky flag SHALL leave flag set.

Reset
REQ-023 On i_reset: FIFOs empty, both FSMs IDLE, divisor = SYS_FREQ/BAUDRATE, IRQ_EN = 0, CTRL = 0, sticky flags 0, o_uart_tx = 1, o_slave_ack = 0, o_int = 0.
REQ-024 Reset mid-frame SHALL abort the frame immediately; o_uart_tx returns high.

Configuration
REQ-025 Macro UART_PERIPH_LOOPBACK_EN SHALL compile in CTRL bit0 (loopback): when set, RX engine input = TX engine output and o_uart_tx held high.
REQ-026 Without UART_PERIPH_LOOPBACK_EN, CTRL SHALL read 0, writes ignored, RX always from i_uart_rx.

Structure
REQ-027 Shared package uart_periph_pkg SHALL hold register address constants, STATUS/IRQ bit indices, FSM state enum, MIN_DIV = 4.
REQ-028 One sub-module uart_periph_fifo (parameters WIDTH, DEPTH_LOG2; push, pop, empty, full, head data) SHALL be instantiated twice.

Verification
REQ-029 Reset -> DIV_LO=0xD9, DIV_HI=0x00 (217), STATUS=0x05, o_uart_tx=1.
REQ-030 Write DIV=16, write 0x55 to DATA -> o_uart_tx low 16 clk, then bits 1,0,1,0,1,0,1,0 each 16 clk, stop high 16 clk.
REQ-031 Drive 9 frames 0x00..0x08 into RX, depth 8 -> rx_full=1, overrun=1, DATA reads 0x00, eight pops yield 0x00..0x07.
REQ-032 Drive frame 0xA3 with stop bit low -> framing_err=1, rx_empty=1; IRQ_EN=0x8 -> o_int=1; STATUS write 0x40 -> o_int=0.
REQ-033 Write DIV=4 (and DIV=2, checked clamped to 4), IRQ_EN=0x2, CTRL=1 with UART_PERIPH_LOOPBACK_EN, write 0x3C -> o_int rises, DATA reads 0x3C, o_uart_tx stays 1.
REQ-034 Assert i_reset during TX DATA state -> o_uart_tx=1 next edge, tx_empty=1, no further frame after release.

Source files
------------

// File: rtl/uart_periph_pkg.sv
// Shared definitions for the uart_periph block: register map, STATUS/IRQ bit positions,
// the engine state enum and the minimum usable divisor.
package uart_periph_pkg;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_DATA   = 3'd1;
  localparam logic [2:0] ADDR_DIV_LO = 3'd2;
  localparam logic [2:0] ADDR_DIV_HI = 3'd3;
  localparam logic [2:0] ADDR_IRQ_EN = 3'd4;
  localparam logic [2:0] ADDR_CTRL   = 3'd5;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_OVERRUN  = 5;
  localparam int ST_FRAMING  = 6;

  localparam int IRQ_TX_EMPTY = 0;
  localparam int IRQ_RX_NE    = 1;
  localparam int IRQ_OVERRUN  = 2;
  localparam int IRQ_FRAMING  = 3;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/uart_periph_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty; push is accepted when full
// only if a pop happens in the same cycle.
module uart_periph_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_empty,
  output logic             o_full,
  output logic [WIDTH-1:0] o_head
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic w_pop_ok;
  logic w_push_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_periph.sv
// 8N1 UART with register interface, RX/TX FIFOs and level interrupt.
// Optional CTRL loopback bit is compiled in by defining UART_PERIPH_LOOPBACK_EN.
//   state   | meaning
//   S_IDLE  | line idle / waiting for FIFO data (TX) or falling edge (RX)
//   S_START | start bit (RX: half-bit qualify)
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit (RX: waits for line high after a framing error)
module uart_periph #(
  parameter int SYS_FREQ      = 25000000,
  parameter int BAUDRATE      = 115200,
  parameter int RX_DEPTH_LOG2 = 3,
  parameter int TX_DEPTH_LOG2 = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_slave_cs,
  input  logic       i_slave_we,
  input  logic [2:0] i_slave_addr,
  input  logic [7:0] i_slave_data,
  output logic [7:0] o_slave_data,
  output logic       o_slave_ack,
  output logic       o_int,
  input  logic       i_uart_rx,
  output logic       o_uart_tx
);
  import uart_periph_pkg::*;

  localparam logic [15:0] RST_DIV = 16'(SYS_FREQ / BAUDRATE);

  logic [15:0] r_div;
  logic [3:0]  r_irq_en;
  logic        r_ack, r_fe, r_ov;
  logic        w_wr, w_loopback;
  logic [15:0] w_div, w_half;

  logic       w_rx_push, w_rx_pop, w_rx_empty, w_rx_full;
  logic       w_tx_push, w_tx_pop, w_tx_empty, w_tx_full;
  logic [7:0] w_rx_head, w_tx_head;

  uart_state_e r_tx_state, r_rx_state;
  logic [15:0] r_tx_cnt, r_rx_cnt;
  logic [2:0]  r_tx_bit, r_rx_bit;
  logic [7:0]  r_tx_shift, r_rx_shift;
  logic        r_tx_line, r_rx_brk;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic        w_tx_tc, w_rx_tc, w_rx_in, w_rx_ferr, w_rx_ovf;

  assign w_wr   = i_slave_cs & i_slave_we;
  assign w_div  = eff_div(r_div);
  assign w_half = {1'b0, w_div[15:1]} - 16'd1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div    <= RST_DIV;
      r_irq_en <= '0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= i_slave_cs;
      if (w_wr) begin
        case (i_slave_addr)
          ADDR_DIV_LO: r_div[7:0]  <= i_slave_data;
          ADDR_DIV_HI: r_div[15:8] <= i_slave_data;
          ADDR_IRQ_EN: r_irq_en    <= i_slave_data[3:0];
          default: ;
        endcase
      end
    end
  end

`ifdef UART_PERIPH_LOOPBACK_EN
  logic r_ctrl_lb;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                r_ctrl_lb <= 1'b0;
    else if (w_wr && i_slave_addr == ADDR_CTRL) r_ctrl_lb <= i_slave_data[0];
  end
  assign w_loopback = r_ctrl_lb;
`else
  assign w_loopback = 1'b0;
`endif

  assign w_tx_push = w_wr && (i_slave_addr == ADDR_DATA);
  assign w_rx_pop  = w_wr && (i_slave_addr == ADDR_STATUS) && i_slave_data[0];

  uart_periph_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .i_clk(i_clk), .i_reset(i_reset), .i_push(w_rx_push), .i_data(r_rx_shift),
    .i_pop(w_rx_pop), .o_empty(w_rx_empty), .o_full(w_rx_full), .o_head(w_rx_head)
  );

  uart_periph_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .i_clk(i_clk), .i_reset(i_reset), .i_push(w_tx_push), .i_data(i_slave_data),
    .i_pop(w_tx_pop), .o_empty(w_tx_empty), .o_full(w_tx_full), .o_head(w_tx_head)
  );

  // Bit counters are reloaded from w_div only at bit boundaries, so divisor writes never stretch a bit.
  assign w_tx_tc  = (r_tx_cnt == 16'd0);
  assign w_tx_pop = !w_tx_empty &&
                    ((r_tx_state == S_IDLE) || (r_tx_state == S_STOP && w_tx_tc));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: if (!w_tx_empty) begin
          r_tx_state <= S_START;
          r_tx_shift <= w_tx_head;
          r_tx_line  <= 1'b0;
          r_tx_cnt   <= w_div - 16'd1;
        end
        S_START: if (w_tx_tc) begin
          r_tx_state <= S_DATA;
          r_tx_line  <= r_tx_shift[0];
          r_tx_bit   <= '0;
          r_tx_cnt   <= w_div - 16'd1;
        end else r_tx_cnt <= r_tx_cnt - 16'd1;
        S_DATA: if (w_tx_tc) begin
          r_tx_cnt <= w_div - 16'd1;
          if (r_tx_bit == 3'd7) begin
            r_tx_state <= S_STOP;
            r_tx_line  <= 1'b1;
          end else begin
            r_tx_bit   <= r_tx_bit + 3'd1;
            r_tx_line  <= r_tx_shift[1];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          end
        end else r_tx_cnt <= r_tx_cnt - 16'd1;
        S_STOP: if (w_tx_tc) begin
          if (!w_tx_empty) begin
            r_tx_state <= S_START;
            r_tx_shift <= w_tx_head;
            r_tx_line  <= 1'b0;
            r_tx_cnt   <= w_div - 16'd1;
          end else r_tx_state <= S_IDLE;
        end else r_tx_cnt <= r_tx_cnt - 16'd1;
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  assign w_rx_in   = w_loopback ? r_tx_line : i_uart_rx;
  assign w_rx_tc   = (r_rx_cnt == 16'd0);
  assign w_rx_push = (r_rx_state == S_STOP) && !r_rx_brk && w_rx_tc && r_rx_s2;
  assign w_rx_ferr = (r_rx_state == S_STOP) && !r_rx_brk && w_rx_tc && !r_rx_s2;
  assign w_rx_ovf  = w_rx_push && w_rx_full && !w_rx_pop;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_brk   <= 1'b0;
    end else begin
      r_rx_s1   <= w_rx_in;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        S_IDLE: if (r_rx_prev && !r_rx_s2) begin
          r_rx_state <= S_START;
          r_rx_cnt   <= w_half;
        end
        S_START: if (w_rx_tc) begin
          if (r_rx_s2) r_rx_state <= S_IDLE;
          else begin
            r_rx_state <= S_DATA;
            r_rx_bit   <= '0;
            r_rx_cnt   <= w_div - 16'd1;
          end
        end else r_rx_cnt <= r_rx_cnt - 16'd1;
        S_DATA: if (w_rx_tc) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_cnt   <= w_div - 16'd1;
          if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
          else                  r_rx_bit   <= r_rx_bit + 3'd1;
        end else r_rx_cnt <= r_rx_cnt - 16'd1;
        S_STOP: if (r_rx_brk) begin
          if (r_rx_s2) begin
            r_rx_state <= S_IDLE;
            r_rx_brk   <= 1'b0;
          end
        end else if (w_rx_tc) begin
          if (r_rx_s2) r_rx_state <= S_IDLE;
          else         r_rx_brk   <= 1'b1;
        end else r_rx_cnt <= r_rx_cnt - 16'd1;
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // Set wins over a same-cycle software clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fe <= 1'b0;
      r_ov <= 1'b0;
    end else begin
      r_fe <= w_rx_ferr | (r_fe & ~(w_wr && i_slave_addr == ADDR_STATUS && i_slave_data[ST_FRAMING]));
      r_ov <= w_rx_ovf  | (r_ov & ~(w_wr && i_slave_addr == ADDR_STATUS && i_slave_data[ST_OVERRUN]));
    end
  end

  always_comb begin
    o_slave_data = 8'h00;
    case (i_slave_addr)
      ADDR_STATUS: o_slave_data = {1'b0, r_fe, r_ov, (r_tx_state != S_IDLE),
                                   w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};
      ADDR_DATA:   o_slave_data = w_rx_head;
      ADDR_DIV_LO: o_slave_data = r_div[7:0];
      ADDR_DIV_HI: o_slave_data = r_div[15:8];
      ADDR_IRQ_EN: o_slave_data = {4'b0000, r_irq_en};
      ADDR_CTRL:   o_slave_data = {7'b0000000, w_loopback};
      default:     o_slave_data = 8'h00;
    endcase
  end

  assign o_slave_ack = r_ack;
  assign o_int       = |(r_irq_en & {r_fe, r_ov, ~w_rx_empty, w_tx_empty});
  assign o_uart_tx   = r_tx_line | w_loopback;

endmodule

// File: tb/tb_uart_periph.sv
// Directed-plus-random bench for uart_periph with a queue-based model of the RX side.
module tb_uart_periph;

  logic       clk = 1'b0;
  logic       rst, cs, we, ack, irq, rx, tx;
  logic [2:0] addr;
  logic [7:0] wdata, rdata;

  always #5 clk = ~clk;

  uart_periph dut (
    .i_clk(clk), .i_reset(rst), .i_slave_cs(cs), .i_slave_we(we),
    .i_slave_addr(addr), .i_slave_data(wdata), .o_slave_data(rdata),
    .o_slave_ack(ack), .o_int(irq), .i_uart_rx(rx), .o_uart_tx(tx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_rxq[$];
  logic       m_fe = 1'b0;
  logic       m_ov = 1'b0;
  localparam int RX_DEPTH = 8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {1'b0, m_fe, m_ov, 1'b0, 1'b0, 1'b1,
            (m_rxq.size() == RX_DEPTH), (m_rxq.size() == 0)};
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk); cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk); cs = 1'b1; we = 1'b0; addr = a;
    #1 d = rdata;
    @(negedge clk); cs = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    chk(tag, d, exp);
  endtask

  // Drives one serial frame and updates the model with what the receiver should make of it.
  task automatic send_rx(input logic [7:0] d, input logic stop_b, input int div);
    @(negedge clk); rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (div) @(negedge clk);
    end
    rx = stop_b;
    repeat (div) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    if (!stop_b) m_fe = 1'b1;
    else if (m_rxq.size() < RX_DEPTH) m_rxq.push_back(d);
    else m_ov = 1'b1;
  endtask

  task automatic wait_tx_low(input int limit, output int waited);
    waited = 0;
    while (tx !== 1'b0 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    chk("tx_start_seen", tx, 1'b0);
  endtask

  task automatic capture_tx(input int div, output logic [7:0] d, output int waited);
    d = 8'h00;
    wait_tx_low(30 * div, waited);
    repeat (div / 2) @(negedge clk);
    chk("tx_start_bit", tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge clk);
      d[i] = tx;
    end
    repeat (div) @(negedge clk);
    chk("tx_stop_bit", tx, 1'b1);
  endtask

  task automatic check_wave(input logic [7:0] v, input int div);
    int waited;
    int mism = 0;
    logic e;
    wait_tx_low(30 * div, waited);
    for (int k = 0; k < 10 * div; k++) begin
      if (k < div)          e = 1'b0;
      else if (k < 9 * div) e = v[(k - div) / div];
      else                  e = 1'b1;
      if (tx !== e) mism++;
      @(negedge clk);
    end
    chk("tx_wave", mism, 0);
    chk("tx_idle_after_wave", tx, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, t[3], r;
    int w, bad;

    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 3'd0; wdata = 8'h00; rx = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_ack", ack, 1'b0);
    chk("rst_int", irq, 1'b0);
    @(negedge clk); rst = 1'b0;

    read_chk("rst_div_lo", 3'd2, 8'hD9);
    read_chk("rst_div_hi", 3'd3, 8'h00);
    read_chk("rst_status", 3'd0, 8'h05);
    read_chk("rst_irq_en", 3'd4, 8'h00);
    read_chk("rst_ctrl",   3'd5, 8'h00);
    bus_write(3'd7, 8'hFF);
    read_chk("addr6_zero", 3'd6, 8'h00);
    read_chk("addr7_zero", 3'd7, 8'h00);

    @(negedge clk); cs = 1'b1; we = 1'b0; addr = 3'd0;
    #1 chk("ack_lead", ack, 1'b0);
    @(negedge clk); #1 chk("ack_high", ack, 1'b1);
    cs = 1'b0;
    @(negedge clk); #1 chk("ack_fall", ack, 1'b0);

    bus_write(3'd2, 8'd16);
    bus_write(3'd3, 8'd0);
    read_chk("div16_lo", 3'd2, 8'd16);

    bus_write(3'd1, 8'h55);
    check_wave(8'h55, 16);
    read_chk("status_after_tx", 3'd0, 8'h05);

    for (int i = 0; i < 3; i++) t[i] = 8'($urandom_range(0, 255));
    fork
      begin
        for (int i = 0; i < 3; i++) bus_write(3'd1, t[i]);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          capture_tx(16, d, w);
          chk("tx_burst_byte", d, t[i]);
          if (i > 0) chk("tx_burst_gap", w, 8);
        end
      end
    join
    repeat (20) @(negedge clk);

    r = 8'($urandom_range(0, 255));
    bus_write(3'd1, r);
    read_chk("status_tx_busy", 3'd0, 8'h15);
    capture_tx(16, d, w);
    chk("tx_single_byte", d, r);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 9; i++) send_rx(8'(i), 1'b1, 16);
    read_chk("rx_full_status", 3'd0, exp_status());
    read_chk("rx_head", 3'd1, m_rxq[0]);
    for (int i = 0; i < 8; i++) begin
      read_chk("rx_pop_data", 3'd1, m_rxq.pop_front());
      bus_write(3'd0, 8'h01);
    end
    read_chk("rx_drained_status", 3'd0, exp_status());
    bus_write(3'd0, 8'h01);
    read_chk("rx_pop_empty_status", 3'd0, exp_status());
    bus_write(3'd0, 8'h20);
    m_ov = 1'b0;
    read_chk("ov_cleared_status", 3'd0, exp_status());

    for (int i = 0; i < 3; i++) send_rx(8'($urandom_range(0, 255)), 1'b1, 16);
    read_chk("rx_rand_status", 3'd0, exp_status());
    while (m_rxq.size() > 0) begin
      read_chk("rx_rand_data", 3'd1, m_rxq.pop_front());
      bus_write(3'd0, 8'h01);
    end

    send_rx(8'hA3, 1'b0, 16);
    read_chk("fe_status", 3'd0, exp_status());
    chk("fe_int_masked", irq, 1'b0);
    bus_write(3'd4, 8'h08);
    chk("fe_int", irq, 1'b1);
    read_chk("irq_en_rb", 3'd4, 8'h08);
    bus_write(3'd0, 8'h40);
    m_fe = 1'b0;
    chk("fe_int_clear", irq, 1'b0);
    read_chk("fe_clear_status", 3'd0, exp_status());
    bus_write(3'd4, 8'h00);

    bus_write(3'd2, 8'd2);
    read_chk("div2_readback", 3'd2, 8'd2);
    r = 8'($urandom_range(0, 255));
    bus_write(3'd1, r);
    capture_tx(4, d, w);
    chk("div_clamped_tx", d, r);
    repeat (10) @(negedge clk);

    bus_write(3'd4, 8'h02);
`ifdef UART_PERIPH_LOOPBACK_EN
    bus_write(3'd5, 8'h01);
    read_chk("ctrl_rb", 3'd5, 8'h01);
    bus_write(3'd1, 8'h3C);
    w = 0; bad = 0;
    while (irq !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
      if (tx !== 1'b1) bad++;
    end
    chk("lb_int", irq, 1'b1);
    chk("lb_tx_held_high", bad, 0);
    read_chk("lb_data", 3'd1, 8'h3C);
    bus_write(3'd0, 8'h01);
    bus_write(3'd5, 8'h00);
`else
    bus_write(3'd5, 8'h01);
    read_chk("ctrl_stays_zero", 3'd5, 8'h00);
    r = 8'($urandom_range(0, 255));
    send_rx(r, 1'b1, 4);
    chk("rx_ne_int", irq, 1'b1);
    read_chk("rx_div4_data", 3'd1, m_rxq.pop_front());
    bus_write(3'd0, 8'h01);
    chk("rx_ne_int_clear", irq, 1'b0);
`endif
    bus_write(3'd4, 8'h00);

    bus_write(3'd2, 8'd16);
    bus_write(3'd1, 8'($urandom_range(0, 255)));
    bus_write(3'd1, 8'($urandom_range(0, 255)));
    wait_tx_low(400, w);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midframe_rst_tx", tx, 1'b1);
    @(negedge clk); rst = 1'b0;
    m_rxq.delete(); m_fe = 1'b0; m_ov = 1'b0;
    read_chk("post_rst_status", 3'd0, exp_status());
    read_chk("post_rst_div_lo", 3'd2, 8'hD9);
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("no_frame_after_rst", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
